// File: rtl/uart_receiver_if.sv
// uart_receiver_if: groups the receiver's serial input, enable and CPU-side
// result signals.
//   enable     receiver enable (master -> receiver)
//   UART_RX    serial line, idle high (master -> receiver)
//   RX_DATA    last good byte (receiver -> master)
//   RX_STATUS  one-cycle strobe when RX_DATA updates (receiver -> master)
//   busy       receiver not idle (receiver -> master)
//   frame_err  sticky stop-bit error flag (receiver -> master)
interface uart_receiver_if;
  logic       enable;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       busy;
  logic       frame_err;

  modport master (
    output enable, UART_RX,
    input  RX_DATA, RX_STATUS, busy, frame_err
  );

  modport slave (
    input  enable, UART_RX,
    output RX_DATA, RX_STATUS, busy, frame_err
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, idle-high line, 16x oversampling.
// Ports:
//   sysclk  system clock, all state on posedge
//   reset   asynchronous active-high reset
//   bus     uart_receiver_if.slave (enable, UART_RX in; RX_DATA, RX_STATUS,
//           busy, frame_err out)
module uart_receiver #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter bit          DATA_INVERT = 1'b0
) (
  input logic            sysclk,
  input logic            reset,
  uart_receiver_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sc_q, sc_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               status_q, status_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               rxs;
  logic               tick_c;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.UART_RX};
  end

  assign rxs = sync_q[1];

  // Oversample tick; the counter is parked at zero while idle
  assign tick_c = (state_q != S_IDLE) && (cnt_q == CNT_W'(DIV - 1));

  // State and datapath registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sc_q     <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sc_q     <= sc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      status_q <= status_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    status_d = 1'b0;
    ferr_d   = ferr_q;

    if (state_q != S_IDLE) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
      if (tick_c) sc_d = sc_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sc_d  = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        // Mid start bit: a high line here was only a glitch
        if (tick_c && sc_q == 4'd7) begin
          if (!rxs) begin
            state_d = S_DATA;
            sc_d    = '0;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_c && sc_q == 4'd15) begin
          shift_d = {rxs ^ DATA_INVERT, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed
        if (tick_c && sc_q == 4'd15) begin
          if (rxs) begin
            data_d   = shift_q;
            ferr_d   = 1'b0;
            status_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait for the line to return high; a held-low line is not a start
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Disable aborts any frame without touching the visible results
    if (!bus.enable) begin
      state_d  = S_IDLE;
      data_d   = data_q;
      ferr_d   = ferr_q;
      status_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.RX_DATA   = data_q;
  assign bus.RX_STATUS = status_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;

endmodule
